// File: rtl/config_pkg.sv
// config_pkg: core configuration slice consumed by the D-cache flush sequencer
// cva6_cfg_t carries D-cache geometry and the invalidate-on-flush policy.
// cva6_cfg_empty is the smallest legal geometry (4 sets, 2 ways, no invalidate).
package config_pkg;
  typedef struct packed {
    int unsigned DCACHE_NUM_WORDS;
    int unsigned DCACHE_SET_ASSOC;
    int unsigned DCACHE_SET_ASSOC_WIDTH;
    int unsigned DCACHE_INDEX_WIDTH;
    int unsigned DCACHE_OFFSET_WIDTH;
    bit          DcacheInvalidateOnFlush;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{
    DCACHE_NUM_WORDS: 4,
    DCACHE_SET_ASSOC: 2,
    DCACHE_SET_ASSOC_WIDTH: 1,
    DCACHE_INDEX_WIDTH: 6,
    DCACHE_OFFSET_WIDTH: 4,
    DcacheInvalidateOnFlush: 1'b0
  };
endpackage

// File: rtl/dcache_flush_pkg.sv
// dcache_flush_pkg: shared state and line-status types for the D-cache flush sequencer
package dcache_flush_pkg;
  typedef enum logic [2:0] {IDLE, READ, CHECK, WB, WB_WAIT, UPD, ADV, DONE} flush_state_e;
  typedef struct packed {
    logic valid;
    logic dirty;
  } line_status_t;
endpackage

// File: rtl/flush_line_cnt.sv
// flush_line_cnt: set/way walk counter, way is the inner loop
// clk_i/rst_i clock and async active-high reset; clr_i zeroes both counters;
// inc_i steps to the next line; idx_o/way_o current line; last_o marks (S-1, W-1).
module flush_line_cnt #(
  parameter int unsigned S = 4,
  parameter int unsigned W = 2,
  localparam int unsigned IW = S > 1 ? $clog2(S) : 1,
  localparam int unsigned WW = W > 1 ? $clog2(W) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [IW-1:0] idx_o,
  output logic [WW-1:0] way_o,
  output logic          last_o
);
  logic way_last;
  assign way_last = way_o == WW'(W - 1);
  assign last_o = way_last && idx_o == IW'(S - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      idx_o <= '0;
      way_o <= '0;
    end else if (clr_i) begin
      idx_o <= '0;
      way_o <= '0;
    end else if (inc_i) begin
      way_o <= way_last ? '0 : way_o + WW'(1);
      if (way_last) idx_o <= last_o ? '0 : idx_o + IW'(1);
    end
endmodule

// File: rtl/dcache_flush_seq.sv
// dcache_flush_seq: walks every D-cache line on a flush, writing back dirty lines and optionally invalidating
// flush_req_i/flush_busy_o/flush_ack_o: start, busy and one-cycle completion pulse.
// line_req_o/line_gnt_i/line_valid_i/line_dirty_i: status read of line (line_idx_o, line_way_o).
// wb_req_o/wb_gnt_i/wb_done_i: writeback of the current line.
// upd_req_o/upd_clr_valid_o/upd_gnt_i: status update (dirty always cleared, valid per policy).
// DCACHE_FLUSH_STATS_EN adds flush_wb_cnt_o, the saturating writeback count of the current/last flush.
module dcache_flush_seq
  import dcache_flush_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  localparam int unsigned IW = CVA6Cfg.DCACHE_INDEX_WIDTH - CVA6Cfg.DCACHE_OFFSET_WIDTH,
  localparam int unsigned WW = CVA6Cfg.DCACHE_SET_ASSOC_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_req_i,
  output logic          flush_busy_o,
  output logic          flush_ack_o,
  output logic          line_req_o,
  output logic [IW-1:0] line_idx_o,
  output logic [WW-1:0] line_way_o,
  input  logic          line_gnt_i,
  input  logic          line_valid_i,
  input  logic          line_dirty_i,
  output logic          wb_req_o,
  input  logic          wb_gnt_i,
  input  logic          wb_done_i,
  output logic          upd_req_o,
  output logic          upd_clr_valid_o,
  input  logic          upd_gnt_i
`ifdef DCACHE_FLUSH_STATS_EN
  , output logic [15:0] flush_wb_cnt_o
`endif
);
  flush_state_e state, state_n;
  line_status_t st;
  logic last;
  assign st = '{valid: line_valid_i, dirty: line_dirty_i};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = flush_req_i ? READ : IDLE;
      READ:    state_n = line_gnt_i ? CHECK : READ;
      CHECK:   state_n = st.valid && st.dirty ? WB :
                         st.valid && CVA6Cfg.DcacheInvalidateOnFlush ? UPD : ADV;
      WB:      state_n = wb_gnt_i ? WB_WAIT : WB;
      WB_WAIT: state_n = wb_done_i ? UPD : WB_WAIT;
      UPD:     state_n = upd_gnt_i ? ADV : UPD;
      ADV:     state_n = last ? DONE : READ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign flush_busy_o = state != IDLE;
  assign flush_ack_o = state == DONE;
  assign line_req_o = state == READ;
  assign wb_req_o = state == WB;
  assign upd_req_o = state == UPD;
  assign upd_clr_valid_o = state == UPD && CVA6Cfg.DcacheInvalidateOnFlush;
  flush_line_cnt #(
    .S(CVA6Cfg.DCACHE_NUM_WORDS),
    .W(CVA6Cfg.DCACHE_SET_ASSOC)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state == IDLE),
    .inc_i (state == ADV),
    .idx_o (line_idx_o),
    .way_o (line_way_o),
    .last_o(last)
  );
`ifdef DCACHE_FLUSH_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) flush_wb_cnt_o <= '0;
    else if (state == IDLE && flush_req_i) flush_wb_cnt_o <= '0;
    else if (state == WB && wb_gnt_i && flush_wb_cnt_o != 16'hFFFF) flush_wb_cnt_o <= flush_wb_cnt_o + 16'd1;
`endif
endmodule
